// File: rtl/line_matrix_cfg.sv
// Shadow routing table for the line matrix; a commit sweeps it out one output per cycle.
// Optional macro LINE_MATRIX_CFG_AUTO_COMMIT_EN: accepted writes also drive the matrix directly.
module line_matrix_cfg #(
  parameter int NUM_INPUTS    = 10,
  parameter int NUM_OUTPUTS   = 10,
  parameter int SETTLE_CYCLES = 2,
  localparam int IW = (NUM_INPUTS  > 1) ? $clog2(NUM_INPUTS)  : 1,
  localparam int OW = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [OW-1:0] cfg_out_idx,
  input  logic [IW-1:0] cfg_in_idx,
  output logic          cfg_err,
  input  logic          commit,
  output logic          busy,
  output logic          done,
  input  logic [OW-1:0] rd_idx,
  output logic [IW-1:0] rd_data,
  output logic [IW-1:0] input_select,
  output logic [OW-1:0] output_select,
  output logic          sel_we
);

  typedef enum logic [1:0] {IDLE, SWEEP, SETTLE, DONE} state_t;

  localparam logic [OW:0]   OUT_LIM   = (OW+1)'(NUM_OUTPUTS);
  localparam logic [IW:0]   IN_LIM    = (IW+1)'(NUM_INPUTS);
  localparam logic [OW-1:0] LAST_OUT  = OW'(NUM_OUTPUTS - 1);
  localparam logic [3:0]    SETTLE_N  = 4'(SETTLE_CYCLES);

  state_t        state_q;
  logic [OW-1:0] cnt_q;
  logic [3:0]    settle_q;
  logic          pending_q;
  logic [IW-1:0] table_q [NUM_OUTPUTS];
  logic [IW-1:0] in_sel_q;
  logic [OW-1:0] out_sel_q;
  logic          sel_we_q;
  logic          done_q;
  logic          err_q;
  logic [IW-1:0] rd_q;

  logic hs, out_ok, in_ok, rd_ok, wr_ok, wr_bad;

  assign hs     = cfg_valid && (state_q == IDLE);
  assign out_ok = {1'b0, cfg_out_idx} < OUT_LIM;
  assign in_ok  = {1'b0, cfg_in_idx} < IN_LIM;
  assign rd_ok  = {1'b0, rd_idx} < OUT_LIM;
  assign wr_ok  = hs && out_ok && in_ok;
  assign wr_bad = hs && !(out_ok && in_ok);

  // Table writes land on the same edge as a commit, so a sweep started there sees them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      settle_q  <= '0;
      pending_q <= 1'b0;
      table_q   <= '{default: '0};
      in_sel_q  <= '0;
      out_sel_q <= '0;
      sel_we_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rd_q      <= '0;
    end else begin
      err_q    <= wr_bad;
      rd_q     <= rd_ok ? table_q[rd_idx] : '0;
      sel_we_q <= 1'b0;
      done_q   <= 1'b0;
      if (wr_ok) begin
        table_q[cfg_out_idx] <= cfg_in_idx;
      end
      case (state_q)
        IDLE: begin
`ifdef LINE_MATRIX_CFG_AUTO_COMMIT_EN
          if (wr_ok) begin
            out_sel_q <= cfg_out_idx;
            in_sel_q  <= cfg_in_idx;
            sel_we_q  <= 1'b1;
          end
`endif
          if (commit || pending_q) begin
            state_q   <= SWEEP;
            cnt_q     <= '0;
            pending_q <= 1'b0;
          end
        end
        SWEEP: begin
          out_sel_q <= cnt_q;
          in_sel_q  <= table_q[cnt_q];
          sel_we_q  <= 1'b1;
          if (commit) begin
            pending_q <= 1'b1;
          end
          if (cnt_q == LAST_OUT) begin
            state_q  <= SETTLE;
            settle_q <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        // The first settle edge only drops sel_we, so zero settle cycles still works.
        SETTLE: begin
          if (commit) begin
            pending_q <= 1'b1;
          end
          if (settle_q == SETTLE_N) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            settle_q <= settle_q + 1'b1;
          end
        end
        default: begin
          if (commit) begin
            pending_q <= 1'b1;
          end
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cfg_ready     = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign cfg_err       = err_q;
  assign rd_data       = rd_q;
  assign input_select  = in_sel_q;
  assign output_select = out_sel_q;
  assign sel_we        = sel_we_q;

endmodule

// File: tb/tb_line_matrix_cfg.sv
// Scoreboard bench for line_matrix_cfg: a cycle-timed reference model queues expected
// select pairs, done/err pulses and readback; a negedge monitor pops and compares.
module tb_line_matrix_cfg;

  localparam int NIN    = 10;
  localparam int NOUT   = 10;
  localparam int SETTLE = 2;
  localparam int IW     = $clog2(NIN);
  localparam int OW     = $clog2(NOUT);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfgValid;
  logic          cfgReady;
  logic [OW-1:0] cfgOutIdx;
  logic [IW-1:0] cfgInIdx;
  logic          cfgErr;
  logic          commit;
  logic          busy;
  logic          done;
  logic [OW-1:0] rdIdx;
  logic [IW-1:0] rdData;
  logic [IW-1:0] inputSelect;
  logic [OW-1:0] outputSelect;
  logic          selWe;

  line_matrix_cfg #(
    .NUM_INPUTS(NIN), .NUM_OUTPUTS(NOUT), .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfgValid), .cfg_ready(cfgReady),
    .cfg_out_idx(cfgOutIdx), .cfg_in_idx(cfgInIdx), .cfg_err(cfgErr),
    .commit(commit), .busy(busy), .done(done),
    .rd_idx(rdIdx), .rd_data(rdData),
    .input_select(inputSelect), .output_select(outputSelect), .sel_we(selWe)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int e; int a; int b;} evT;

  evT pairQ[$];
  evT rdQ[$];
  int doneQ[$];
  int errQ[$];
  int tbl[NOUT];
  int curStart = -100;
  int curDone  = -100;
  bit pendingM = 1'b0;
  bit monOn = 1'b0;
  int checks = 0;
  int errors = 0;
  int doneCount = 0;

  function automatic evT mkEv(int e, int a, int b);
    evT x;
    x.e = e;
    x.a = a;
    x.b = b;
    return x;
  endfunction

  task automatic checkOutput(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Window after edge e is busy from the commit edge through the done edge.
  function automatic bit busyAt(int e);
    return (e >= curStart) && (e <= curDone);
  endfunction

  task automatic startSweep(int t);
    pendingM = 1'b0;
    for (int o = 0; o < NOUT; o++) pairQ.push_back(mkEv(t + 1 + o, o, tbl[o]));
    curStart = t;
    curDone  = t + NOUT + SETTLE + 1;
    doneQ.push_back(curDone);
  endtask

  task automatic modelReset();
    pairQ.delete();
    rdQ.delete();
    doneQ.delete();
    errQ.delete();
    for (int k = 0; k < NOUT; k++) tbl[k] = 0;
    curStart = -100;
    curDone  = -100;
    pendingM = 1'b0;
  endtask

  // Drives one cycle of inputs for the coming edge and updates the reference model.
  task automatic applyStimulus(bit v, int o, int i, bit c, int r);
    int t;
    bit idle;
    t = cyc + 1;
    cfgValid  = v;
    cfgOutIdx = o[OW-1:0];
    cfgInIdx  = i[IW-1:0];
    commit    = c;
    rdIdx     = r[OW-1:0];
    idle = !busyAt(t - 1);
    rdQ.push_back(mkEv(t, r, (r < NOUT) ? tbl[r] : 0));
    if (v && idle) begin
      if (o < NOUT && i < NIN) begin
        tbl[o] = i;
`ifdef LINE_MATRIX_CFG_AUTO_COMMIT_EN
        pairQ.push_back(mkEv(t, o, i));
`endif
      end else begin
        errQ.push_back(t);
      end
    end
    if (idle && (c || pendingM)) startSweep(t);
    else if (!idle && c) pendingM = 1'b1;
    @(negedge clk);
  endtask

  task automatic idleSteps(int n, int r);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 0, 0, 1'b0, r);
  endtask

  task automatic checkResetOutputs(string tag);
    checkOutput({tag, " sel_we"}, int'(selWe), 0);
    checkOutput({tag, " output_select"}, int'(outputSelect), 0);
    checkOutput({tag, " input_select"}, int'(inputSelect), 0);
    checkOutput({tag, " busy"}, int'(busy), 0);
    checkOutput({tag, " done"}, int'(done), 0);
    checkOutput({tag, " cfg_err"}, int'(cfgErr), 0);
    checkOutput({tag, " rd_data"}, int'(rdData), 0);
    checkOutput({tag, " cfg_ready"}, int'(cfgReady), 1);
  endtask

  task automatic applyReset();
    #2 rst = 1'b1;
    cfgValid = 1'b0;
    commit   = 1'b0;
    #1 checkResetOutputs("async reset");
    modelReset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    bit expW, expD, expE, expB;
    if (monOn && !rst) begin
      expW = (pairQ.size() > 0) && (pairQ[0].e == cyc);
      checkOutput("sel_we", int'(selWe), int'(expW));
      if (expW) begin
        checkOutput("output_select", int'(outputSelect), pairQ[0].a);
        checkOutput("input_select", int'(inputSelect), pairQ[0].b);
        pairQ.pop_front();
      end
      expD = (doneQ.size() > 0) && (doneQ[0] == cyc);
      checkOutput("done", int'(done), int'(expD));
      if (expD) doneQ.pop_front();
      if (done) doneCount++;
      expE = (errQ.size() > 0) && (errQ[0] == cyc);
      checkOutput("cfg_err", int'(cfgErr), int'(expE));
      if (expE) errQ.pop_front();
      if ((rdQ.size() > 0) && (rdQ[0].e == cyc)) begin
        checkOutput($sformatf("rd_data[%0d]", rdQ[0].a), int'(rdData), rdQ[0].b);
        rdQ.pop_front();
      end
      expB = busyAt(cyc);
      checkOutput("busy", int'(busy), int'(expB));
      checkOutput("cfg_ready", int'(cfgReady), int'(!expB));
    end
  end

  initial begin
    int d0;
    cfgValid = 1'b0; cfgOutIdx = '0; cfgInIdx = '0; commit = 1'b0; rdIdx = '0;
    modelReset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    monOn = 1'b1;
    checkResetOutputs("reset state");

    for (int r = 0; r < 12; r++) applyStimulus(1'b0, 0, 0, 1'b0, r);

    // Two table writes, then a full sweep with settle and done.
    d0 = doneCount;
    applyStimulus(1'b1, 3, 7, 1'b0, 3);
    applyStimulus(1'b1, 9, 1, 1'b0, 9);
    applyStimulus(1'b0, 0, 0, 1'b1, 3);
    idleSteps(20, 9);
    checkOutput("single sweep done pulses", doneCount - d0, 1);

    // Out-of-range writes are rejected and leave the table alone.
    applyStimulus(1'b1, 10, 5, 1'b0, 10);
    applyStimulus(1'b1, 3, 12, 1'b0, 3);
    applyStimulus(1'b0, 0, 0, 1'b0, 3);
    idleSteps(3, 15);

    // Repeated commits during a sweep collapse into a single extra sweep.
    d0 = doneCount;
    applyStimulus(1'b0, 0, 0, 1'b1, 0);
    idleSteps(3, 3);
    applyStimulus(1'b0, 0, 0, 1'b1, 3);
    idleSteps(3, 3);
    applyStimulus(1'b1, 4, 4, 1'b1, 4);
    idleSteps(40, 4);
    checkOutput("pending sweep done pulses", doneCount - d0, 2);

    // Write and commit on the same edge: the sweep carries the new entry.
    applyStimulus(1'b1, 5, 8, 1'b1, 5);
    idleSteps(20, 5);

    // Asynchronous reset while output 5 is on the select bus.
    applyStimulus(1'b0, 0, 0, 1'b1, 9);
    idleSteps(6, 9);
    applyReset();
    applyStimulus(1'b0, 0, 0, 1'b0, 3);
    applyStimulus(1'b0, 0, 0, 1'b0, 9);
    applyStimulus(1'b0, 0, 0, 1'b1, 0);
    idleSteps(20, 0);

    for (int k = 0; k < 600; k++) begin
      applyStimulus(($urandom_range(0, 9) < 4), $urandom_range(0, 11), $urandom_range(0, 11),
                    ($urandom_range(0, 29) == 0), $urandom_range(0, 15));
    end

    for (int k = 0; k < 100; k++) begin
      if (pairQ.size() == 0 && doneQ.size() == 0 && errQ.size() == 0 && !pendingM) break;
      applyStimulus(1'b0, 0, 0, 1'b0, $urandom_range(0, 15));
    end
    @(negedge clk);
    checkOutput("drain pairs left", pairQ.size(), 0);
    checkOutput("drain done left", doneQ.size(), 0);
    checkOutput("drain err left", errQ.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
